fifo_serial_tx: RTL
===================

Name: fifo_serial_tx

Overview:
Downstream drain stage for the FIFO example design. It pops words from the FIFO read port and serialises each one onto the single-bit out_port as an asynchronous-style frame: start bit, DATA_W data bits LSB first, then a stop bit. It runs on the same clock as the FIFO and is reset by the same kill signal.

Parameters:
DATA_W, 8, FIFO word width and number of data bits per frame.
CLK_DIV, 4, clock cycles per serial bit. Legal range is 1 or more; a value of 0 is rejected at elaboration.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
kill  input  1  synchronous reset, active-high.
fifo_empty  input  1  FIFO empty flag.
fifo_dout  input  DATA_W  FIFO read data, valid exactly 1 cycle after fifo_rd (non-show-ahead).
fifo_rd  output  1  FIFO read request, one-cycle pulse.
out_port  output  1  serial line; idle level is 1.
busy  output  1  high from the fifo_rd cycle through the last stop-bit cycle.
frame_done  output  1  one-cycle pulse in the cycle after the last stop-bit cycle.

Behaviour:
- Reset values: out_port=1, fifo_rd=0, busy=0, frame_done=0. State=IDLE, bit counter=0, shift register=0.
- States: IDLE, FETCH, LATCH, START, DATA, STOP.
- IDLE: out_port=1. If fifo_empty=0, then fifo_rd=1 and busy=1 this cycle; go to FETCH. fifo_rd is a combinational decode of IDLE and !fifo_empty.
- FETCH: a 1-cycle wait while the FIFO presents data; fifo_rd=0. Go to LATCH.
- LATCH: load fifo_dout into the shift register; go to START. out_port is still 1.
- START: out_port=0 for CLK_DIV cycles.
- DATA: out_port=shift[0] for CLK_DIV cycles per bit. Shift right on each bit boundary. Exactly DATA_W bits are sent.
- STOP: out_port=1 for CLK_DIV cycles, then return to IDLE.
- frame_done=1 and busy=0 in the first IDLE cycle after STOP.
- Latency: if fifo_rd is high in cycle T, the start bit drives cycles T+3 through T+2+CLK_DIV. The frame occupies (DATA_W+2)*CLK_DIV cycles.
- Back-to-back words: the minimum spacing from one fifo_rd to the next is (DATA_W+2)*CLK_DIV+3 cycles, which is 43 at the defaults. There is exactly one IDLE cycle between frames, and frame_done coincides with the next fifo_rd.
- Bit timer: counts 0..CLK_DIV-1 and asserts tick at CLK_DIV-1. It is cleared on entry to START. Width is max(1, clog2(CLK_DIV)).
- Bit index: counts 0..DATA_W-1 inside DATA. Width is max(1, clog2(DATA_W)).
- Empty handling: fifo_empty is only sampled in IDLE. A word arriving mid-frame is fetched only after STOP completes. fifo_rd is never asserted while fifo_empty=1.
- kill mid-frame: on the next edge all outputs go to reset values. A popped word that has not yet been fully sent is discarded and not re-read. kill dominates every other condition.
- CLK_DIV=1: a bit lasts one cycle, with no other change in behaviour.

Decomposition:
- Shared package fifo_serial_pkg, containing:
  - the state enum/localparams (IDLE, FETCH, LATCH, START, DATA, STOP, 3-bit encoding);
  - constants LINE_IDLE=1, START_BIT=0, STOP_BIT=1;
  - a clog2-based width helper.
- Sub-module fifo_serial_bit_timer (clk, kill, clear, tick), parameterised by CLK_DIV. It is reused later by the RX side.

Test Plan:
- Idle after reset: hold kill=1 for 5 cycles, then release with fifo_empty=1 for 50 cycles -> out_port=1, fifo_rd=0, busy=0 throughout.
- Single word: FIFO holds 8'hA5 -> fifo_rd is pulsed once. out_port sequence is 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles and starting 3 cycles after fifo_rd. frame_done pulses 40 cycles after the start bit begins.
- Back-to-back: FIFO holds 8'h00 then 8'hFF -> the second fifo_rd is exactly 43 cycles after the first. Line pattern is 0 followed by eight 0 bits then 1, a single idle cycle, then 0 followed by eight 1 bits then 1.
- Empty mid-frame: fifo_empty rises during the DATA phase of word 8'h3C -> the frame completes unchanged and no further fifo_rd occurs.
- kill mid-frame: assert kill at bit 4 of 8'h81 -> on the next edge out_port=1 and busy=0. After release the next FIFO word is fetched and sent correctly; 8'h81 is not retransmitted.
- CLK_DIV=1, DATA_W=8: 8'h5A -> each bit lasts 1 cycle, the frame is 10 cycles, and back-to-back spacing is 13 cycles.

Source files
------------

// File: rtl/fifo_serial_pkg.sv
// Shared definitions for the FIFO serial drain stage (TX now, RX later).
package fifo_serial_pkg;

  // Frame sequencer states, 3-bit encoding.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_START = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_STOP  = 3'd5;

  // Serial line levels.
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/fifo_serial_bit_timer.sv
// Bit-period timer: counts 0..CLK_DIV-1 and flags the last cycle of each bit.
module fifo_serial_bit_timer
  import fifo_serial_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic kill,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W   = width_of(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  generate
    if (CLK_DIV < 1) begin : g_bad_div
      $error("fifo_serial_bit_timer: CLK_DIV must be at least 1");
    end
  endgenerate

  logic [CNT_W-1:0] count;

  // Free-running bit-period counter, restarted by clear so a new frame starts on a bit edge.
  always_ff @(posedge clk) begin
    if (kill) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count == CNT_MAX) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == CNT_MAX);

endmodule

// File: rtl/fifo_serial_tx.sv
// FIFO drain stage: pops one word at a time and sends it as start bit,
// DATA_W data bits LSB first, stop bit, each held CLK_DIV cycles.
module fifo_serial_tx
  import fifo_serial_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              kill,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd,
  output logic              out_port,
  output logic              busy,
  output logic              frame_done
);

  localparam int               IDX_W    = width_of(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_next;
  logic [IDX_W-1:0]  bit_idx;
  logic [IDX_W-1:0]  bit_idx_next;
  logic              out_next;
  logic              done_next;
  logic              tick;
  logic              timer_clear;

  // Restart the bit timer in LATCH so the start bit gets a full period.
  assign timer_clear = (state == ST_LATCH);

  fifo_serial_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .clk   (clk),
    .kill  (kill),
    .clear (timer_clear),
    .tick  (tick)
  );

  // The read request must reach the FIFO in the same cycle IDLE sees data;
  // kill suppresses it so no word is popped while resetting.
  assign fifo_rd = (state == ST_IDLE) && !fifo_empty && !kill;
  assign busy    = (state != ST_IDLE) || fifo_rd;

  // Next-state, shift and line-level decode for the frame sequencer.
  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_idx_next = bit_idx;
    done_next    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_next = ST_FETCH;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_next = ST_LATCH;
      end
      ST_LATCH: begin
        shift_next = fifo_dout;
        state_next = ST_START;
      end
      ST_START: begin
        if (tick) begin
          bit_idx_next = '0;
          state_next   = ST_DATA;
        end else begin
          state_next = ST_START;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_next = shift >> 1;
          if (bit_idx == IDX_LAST) begin
            state_next = ST_STOP;
          end else begin
            bit_idx_next = bit_idx + IDX_W'(1);
            state_next   = ST_DATA;
          end
        end else begin
          state_next = ST_DATA;
        end
      end
      ST_STOP: begin
        if (tick) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          state_next = ST_STOP;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Line level is computed for the upcoming cycle so out_port can be a flop.
    case (state_next)
      ST_START: out_next = START_BIT;
      ST_DATA:  out_next = shift_next[0];
      ST_STOP:  out_next = STOP_BIT;
      default:  out_next = LINE_IDLE;
    endcase
  end

  // Sequencer state and registered line/done outputs; kill overrides everything.
  always_ff @(posedge clk) begin
    if (kill) begin
      state      <= ST_IDLE;
      shift      <= '0;
      bit_idx    <= '0;
      out_port   <= LINE_IDLE;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      shift      <= shift_next;
      bit_idx    <= bit_idx_next;
      out_port   <= out_next;
      frame_done <= done_next;
    end
  end

endmodule
